// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchronizes and de-glitches kbd clock/data, frames 11-bit words, decodes E0/F0 prefixes.
// Latency: valid/err pulse one cycle after the stop-bit fall is processed; the PS/2 lines are only sampled, never driven.
module ps2_kbd_rx #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 50_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] kbd,
    output logic [7:0] code,
    output logic       ext,
    output logic       brk,
    output logic       valid,
    output logic       err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [1:0]         s1_q, s2_q, filt_q;
    logic [1:0][FW-1:0] fcnt_q;
    logic               clk_prev_q;
    logic               fall;
    logic               dat;

    state_t             state_q;
    logic [2:0]         bit_q;
    logic [7:0]         sh_q;
    logic               par_q;
    logic [TW-1:0]      to_q;
    logic               pend_e0_q, pend_f0_q;

    // A line's filtered level only moves after FILTER_LEN consecutive disagreeing samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q       <= 2'b11;
            s2_q       <= 2'b11;
            filt_q     <= 2'b11;
            fcnt_q     <= '0;
            clk_prev_q <= 1'b1;
        end else begin
            s1_q       <= kbd;
            s2_q       <= s1_q;
            clk_prev_q <= filt_q[0];
            for (int i = 0; i < 2; i++) begin
                if (s2_q[i] != filt_q[i]) begin
                    if (fcnt_q[i] == FILT_LAST) begin
                        filt_q[i] <= s2_q[i];
                        fcnt_q[i] <= '0;
                    end else begin
                        fcnt_q[i] <= fcnt_q[i] + 1'b1;
                    end
                end else begin
                    fcnt_q[i] <= '0;
                end
            end
        end
    end

    assign fall = clk_prev_q & ~filt_q[0];
    assign dat  = filt_q[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_q     <= '0;
            sh_q      <= '0;
            par_q     <= 1'b0;
            to_q      <= '0;
            pend_e0_q <= 1'b0;
            pend_f0_q <= 1'b0;
            code      <= 8'h00;
            ext       <= 1'b0;
            brk       <= 1'b0;
            valid     <= 1'b0;
            err       <= 1'b0;
        end else begin
            valid <= 1'b0;
            err   <= 1'b0;
            if (state_q == IDLE) begin
                to_q <= '0;
                if (fall) begin
                    if (!dat) begin
                        state_q <= DATA;
                        bit_q   <= '0;
                    end else begin
                        err <= 1'b1;
                    end
                end
            end else if (fall) begin
                // A fall always beats a simultaneous timeout.
                to_q <= '0;
                case (state_q)
                    DATA: begin
                        sh_q[bit_q] <= dat;
                        if (bit_q == 3'd7) begin
                            state_q <= PARITY;
                        end else begin
                            bit_q <= bit_q + 3'd1;
                        end
                    end
                    PARITY: begin
                        par_q   <= dat;
                        state_q <= STOP;
                    end
                    default: begin
                        state_q <= IDLE;
                        if (dat && (^{sh_q, par_q})) begin
                            if (sh_q == 8'hE0) begin
                                pend_e0_q <= 1'b1;
                            end else if (sh_q == 8'hF0) begin
                                pend_f0_q <= 1'b1;
                            end else begin
                                code      <= sh_q;
                                ext       <= pend_e0_q;
                                brk       <= pend_f0_q;
                                valid     <= 1'b1;
                                pend_e0_q <= 1'b0;
                                pend_f0_q <= 1'b0;
                            end
                        end else begin
                            err       <= 1'b1;
                            pend_e0_q <= 1'b0;
                            pend_f0_q <= 1'b0;
                        end
                    end
                endcase
            end else if (to_q == TO_LAST) begin
                state_q   <= IDLE;
                to_q      <= '0;
                err       <= 1'b1;
                pend_e0_q <= 1'b0;
                pend_f0_q <= 1'b0;
            end else begin
                to_q <= to_q + 1'b1;
            end
        end
    end

endmodule
